// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator: one shared divider drives an oversample tick, a TX bit enable and a re-phasable RX mid-bit strobe.
// Latency: first os_tick is registered div_int edges after en is first sampled high; every output is a registered one-cycle pulse.
// Backpressure: none; free-running pulse source. Divisor changes are shadowed and only applied at a TX bit boundary.
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              tx_enb,
  output logic              rx_enb,
  output logic              cfg_err
);

  localparam int PH_W = $clog2(OSR);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]  PH_MID_M1 = PH_W'(OSR / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);

  // run_q marks that en was already high on the previous edge; the edge that
  // first sees en=1 only arms the divider, so the first tick lands div_int
  // edges later rather than div_int-1.
  logic              run_q, run_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [PH_W-1:0]   tx_ph_q, tx_ph_d;
  logic [PH_W-1:0]   rx_ph_q, rx_ph_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              os_tick_q, os_tick_d;
  logic              tx_enb_q, tx_enb_d;
  logic              rx_enb_q, rx_enb_d;
  logic              cfg_err_q, cfg_err_d;

  logic              in_err;
  logic [DIV_W-1:0]  div_clamp;
  logic [DIV_W-1:0]  len_m1;
  logic [FRAC_W:0]   acc_sum;
  logic              period_end;

  // The shadow holds an already-clamped divisor, so div_q >= 2 and
  // div_q - 1 + carry never exceeds 2^DIV_W - 1: no counter overflow.
  assign in_err     = (div_int < DIV_MIN);
  assign div_clamp  = in_err ? DIV_MIN : div_int;
  assign len_m1     = div_q - DIV_W'(1) + DIV_W'(carry_q);
  assign acc_sum    = {1'b0, acc_q} + {1'b0, frac_q};
  assign period_end = run_q && (cnt_q == len_m1);

  // Next-state: divider, fractional accumulator, TX/RX phases, shadow config and pulses.
  always_comb begin
    run_d     = en;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    tx_ph_d   = tx_ph_q;
    rx_ph_d   = rx_ph_q;
    div_d     = div_q;
    frac_d    = frac_q;
    cfg_err_d = cfg_err_q;
    os_tick_d = 1'b0;
    tx_enb_d  = 1'b0;
    rx_enb_d  = 1'b0;

    if (!en) begin
      // Idle: everything parked at zero, shadow tracks the ports.
      cnt_d     = '0;
      acc_d     = '0;
      carry_d   = 1'b0;
      tx_ph_d   = '0;
      rx_ph_d   = '0;
      div_d     = div_clamp;
      frac_d    = div_frac;
      cfg_err_d = in_err;
    end else if (period_end) begin
      cnt_d              = '0;
      {carry_d, acc_d}   = acc_sum;
      os_tick_d          = 1'b1;
      if (tx_ph_q == PH_LAST) begin
        // Bit boundary: the only point where a running generator picks up new config.
        tx_ph_d   = '0;
        tx_enb_d  = 1'b1;
        div_d     = div_clamp;
        frac_d    = div_frac;
        cfg_err_d = in_err;
      end else begin
        tx_ph_d = tx_ph_q + PH_W'(1);
      end
      rx_ph_d  = (rx_ph_q == PH_LAST) ? '0 : rx_ph_q + PH_W'(1);
      rx_enb_d = (rx_ph_q == PH_MID_M1);
    end else if (run_q) begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // A start-bit edge re-phases RX only; it wins over a coincident tick.
    if (rx_resync) begin
      rx_ph_d  = '0;
      rx_enb_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset; reset reloads the shadow from the ports.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      tx_ph_q   <= '0;
      rx_ph_q   <= '0;
      div_q     <= div_clamp;
      frac_q    <= div_frac;
      os_tick_q <= 1'b0;
      tx_enb_q  <= 1'b0;
      rx_enb_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      tx_ph_q   <= tx_ph_d;
      rx_ph_q   <= rx_ph_d;
      div_q     <= div_d;
      frac_q    <= frac_d;
      os_tick_q <= os_tick_d;
      tx_enb_q  <= tx_enb_d;
      rx_enb_q  <= rx_enb_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign os_tick = os_tick_q;
  assign tx_enb  = tx_enb_q;
  assign rx_enb  = rx_enb_q;
  assign cfg_err = cfg_err_q;

endmodule
